// File: rtl/im_loader.sv
`default_nettype none
// ============================================================================
// Module   : im_loader
// Purpose  : Streams a program into instruction memory one byte at a time.
//            Bytes are packed into 32-bit words, little-endian. The pipeline
//            core is held in reset until the load completes, and then runs
//            from the loaded memory.
// Revision : 1.0  initial release
// ============================================================================
module im_loader #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic [DEPTH_LOG2:0]   load_len,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  input  logic [31:0]           IM_addr,
  output logic [31:0]           IM_out,
  output logic                  cpu_rst,
  output logic                  load_done,
  output logic [DEPTH_LOG2:0]   words_loaded,
  output logic [31:0]           checksum
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  localparam int                DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] MAX_WORDS = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] ONE_WORD  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0] NO_WORDS  = '0;

  logic [1:0]            state;
  logic [1:0]            byte_cnt;
  logic [23:0]           partial;     // first three bytes of the word in flight
  logic [DEPTH_LOG2:0]   target_len;  // effective (clamped) length of this load
  logic [31:0]           mem [DEPTH];

  logic                  xfer;
  logic                  word_we;
  logic [31:0]           full_word;
  logic [DEPTH_LOG2:0]   clamped_len;
  logic [DEPTH_LOG2:0]   words_next;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  unused_addr_bits;

  // Ready follows the registered state only; reset blocks any transfer.
  assign byte_ready  = (state == LOAD) && !rst;
  assign xfer        = byte_ready && byte_valid;
  assign word_we     = xfer && (byte_cnt == 2'd3);
  assign full_word   = {byte_data, partial};
  assign clamped_len = (load_len > MAX_WORDS) ? MAX_WORDS : load_len;
  assign words_next  = words_loaded + ONE_WORD;
  // words_loaded never reaches MAX_WORDS while a write is pending, so the
  // low bits are always a valid index.
  assign wr_idx      = words_loaded[DEPTH_LOG2-1:0];
  // Byte address to word index; the byte offset and upper bits are dropped.
  assign rd_idx      = IM_addr[DEPTH_LOG2+1:2];
  assign unused_addr_bits = ^{IM_addr[31:DEPTH_LOG2+2], IM_addr[1:0]};

  assign cpu_rst = rst || (state != RUN);

  // Control FSM, byte packing, word counter and running checksum.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      byte_cnt     <= 2'd0;
      partial      <= 24'h0;
      words_loaded <= NO_WORDS;
      checksum     <= 32'h0;
      load_done    <= 1'b0;
      target_len   <= NO_WORDS;
    end else begin
      load_done <= 1'b0;
      case (state)
        IDLE, RUN: begin
          // A reload from RUN behaves exactly like a fresh start.
          if (load_start) begin
            target_len   <= clamped_len;
            words_loaded <= NO_WORDS;
            checksum     <= 32'h0;
            byte_cnt     <= 2'd0;
            if (clamped_len == NO_WORDS) begin
              state     <= RUN;
              load_done <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          // load_start is deliberately not looked at here.
          if (xfer) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0:    partial[7:0]   <= byte_data;
              2'd1:    partial[15:8]  <= byte_data;
              2'd2:    partial[23:16] <= byte_data;
              default: ;
            endcase
            if (word_we) begin
              words_loaded <= words_next;
              checksum     <= checksum + full_word;
              if (words_next == target_len) begin
                state     <= RUN;
                load_done <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Single write port; contents survive reset and reloads.
  always_ff @(posedge clk) begin
    if (word_we) begin
      mem[wr_idx] <= full_word;
    end
  end

  // Instruction fetch is only exposed while the core is running.
  always_comb begin
    IM_out = 32'h0;
    if (state == RUN) begin
      IM_out = mem[rd_idx];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_im_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_im_loader
// Purpose  : Self-checking bench for im_loader (DEPTH_LOG2 = 4, 16 words).
//            Directed scenarios plus random traffic against a queue-based
//            reference model; outputs compared on every falling edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_im_loader;

  localparam int D = 4;
  localparam int NW = 1 << D;

  logic         clk = 1'b0;
  logic         rst;
  logic         load_start;
  logic [D:0]   load_len;
  logic         byte_valid;
  logic [7:0]   byte_data;
  logic         byte_ready;
  logic [31:0]  IM_addr;
  logic [31:0]  IM_out;
  logic         cpu_rst;
  logic         load_done;
  logic [D:0]   words_loaded;
  logic [31:0]  checksum;

  im_loader #(.DEPTH_LOG2(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_start   (load_start),
    .load_len     (load_len),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .IM_addr      (IM_addr),
    .IM_out       (IM_out),
    .cpu_rst      (cpu_rst),
    .load_done    (load_done),
    .words_loaded (words_loaded),
    .checksum     (checksum)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2;
  int          mode;
  logic [7:0]  bq[$];
  int          m_target;
  int          m_words;
  logic [31:0] m_sum;
  bit          m_done;
  logic [31:0] m_mem[NW];
  bit          known[NW];
  bit          model_on = 0;

  // Advance the model on each rising edge from the driven inputs.
  always @(posedge clk) begin
    logic [31:0] w;
    model_on = 1;
    if (rst) begin
      mode = M_IDLE; bq.delete(); m_words = 0; m_sum = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (mode != M_LOAD && load_start) begin
        m_target = (int'(load_len) > NW) ? NW : int'(load_len);
        m_words = 0; m_sum = 0; bq.delete();
        if (m_target == 0) begin mode = M_RUN; m_done = 1; end
        else mode = M_LOAD;
      end else if (mode == M_LOAD && byte_valid) begin
        bq.push_back(byte_data);
        if (bq.size() == 4) begin
          w = {bq[3], bq[2], bq[1], bq[0]};
          bq.delete();
          m_mem[m_words] = w;
          known[m_words] = 1;
          m_words++;
          m_sum += w;
          if (m_words == m_target) begin mode = M_RUN; m_done = 1; end
        end
      end
    end
  end

  // Compare every DUT output with the model away from the active edge.
  always @(negedge clk) begin
    int idx;
    if (model_on) begin
      check("byte_ready", byte_ready, (mode == M_LOAD) && !rst);
      check("cpu_rst", cpu_rst, rst || (mode != M_RUN));
      check("load_done", load_done, m_done);
      check("words_loaded", words_loaded, m_words);
      check("checksum", checksum, m_sum);
      idx = int'(IM_addr[D+1:2]);
      if (mode != M_RUN) check("IM_out_zero", IM_out, 32'h0);
      else if (known[idx]) check("IM_out_run", IM_out, m_mem[idx]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_load(input int len);
    load_start = 1'b1; load_len = len[D:0];
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1; byte_data = b;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] addr, input string name, input logic [31:0] exp);
    IM_addr = addr; #1;
    check(name, IM_out, exp);
  endtask

  initial begin
    rst = 1'b1; load_start = 1'b0; load_len = '0; byte_valid = 1'b0;
    byte_data = 8'h0; IM_addr = 32'h0;
    tick(); tick();
    check("rst_cpu_rst", cpu_rst, 1'b1);
    check("rst_words", words_loaded, 0);
    check("rst_sum", checksum, 32'h0);
    check("rst_ready", byte_ready, 1'b0);
    check("rst_done", load_done, 1'b0);
    rst = 1'b0;
    tick();

    // Two-word load with byte_valid held high.
    start_load(2);
    for (int i = 1; i <= 8; i++) begin
      byte_valid = 1'b1; byte_data = i[7:0]; tick();
    end
    byte_valid = 1'b0;
    check("l2_done", load_done, 1'b1);
    check("l2_cpu_rst", cpu_rst, 1'b0);
    check("l2_words", words_loaded, 2);
    check("l2_sum", checksum, 32'h0C0A0806);
    tick();
    check("l2_done_drop", load_done, 1'b0);
    fetch(32'h4, "fetch_4", 32'h08070605);
    fetch(32'h7, "fetch_7", 32'h08070605);
    fetch(32'h0, "fetch_0", 32'h04030201);

    // Zero-length load from RUN; stray bytes must be ignored.
    byte_valid = 1'b1; byte_data = 8'hAA;
    start_load(0);
    check("l0_done", load_done, 1'b1);
    check("l0_ready", byte_ready, 1'b0);
    check("l0_words", words_loaded, 0);
    check("l0_sum", checksum, 32'h0);
    tick();
    byte_valid = 1'b0;

    // One word with byte_valid toggling.
    start_load(1);
    for (int i = 0; i < 8; i++) begin
      byte_valid = (i % 2 == 0);
      byte_data  = byte_valid ? 8'((i / 2 + 1) * 8'h11) : 8'h55;
      tick();
    end
    byte_valid = 1'b0;
    check("tog_words", words_loaded, 1);
    fetch(32'h0, "tog_word0", 32'h44332211);
    fetch(32'h4, "tog_word1", 32'h08070605);

    // Reset after six of eight bytes, then a one-word load.
    start_load(2);
    for (int i = 0; i < 6; i++) send_byte(8'h90 + 8'(i));
    rst = 1'b1; tick(); rst = 1'b0;
    check("abort_cpu_rst", cpu_rst, 1'b1);
    check("abort_words", words_loaded, 0);
    start_load(1);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    fetch(32'h0, "dead_word0", 32'hDEADBEEF);
    fetch(32'h4, "dead_word1", 32'h08070605);

    // Reload from RUN with 0xFF bytes.
    start_load(1);
    check("reload_cpu_rst", cpu_rst, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'hFF);
    check("reload_sum", checksum, 32'hFFFFFFFF);
    fetch(32'h0, "reload_word0", 32'hFFFFFFFF);
    fetch(32'h4, "reload_word1", 32'h08070605);

    // load_start during LOAD is ignored.
    start_load(2);
    send_byte(8'h01); send_byte(8'h02);
    load_start = 1'b1; load_len = 5'd0; send_byte(8'h03); load_start = 1'b0;
    for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i));
    check("ign_words", words_loaded, 2);

    // Oversized length is clamped to the memory depth.
    start_load(31);
    for (int i = 0; i < 4 * NW; i++) send_byte(8'($urandom));
    check("clamp_words", words_loaded, NW);
    check("clamp_done", load_done, 1'b1);
    tick();

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      rst        = ($urandom_range(0, 299) == 0);
      load_start = ($urandom_range(0, 39) == 0);
      load_len   = 5'($urandom_range(0, 20));
      byte_valid = $urandom_range(0, 1) == 1;
      byte_data  = 8'($urandom);
      IM_addr    = $urandom;
      tick();
    end
    rst = 1'b0; load_start = 1'b0; byte_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 Parameter DEPTH_LOG2, default 10, log2 of instruction-memory depth in 32-bit words.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 load_start  input  1  one-cycle request to begin a program load.
REQ-005 load_len  input  DEPTH_LOG2+1  number of words to load, sampled with load_start.
REQ-006 byte_valid  input  1  upstream byte available.
REQ-007 byte_data  input  8  program byte.
REQ-008 byte_ready  output  1  loader accepts byte this cycle.
REQ-009 IM_addr  input  32  CPU fetch byte address (pc_output).
REQ-010 IM_out  output  32  instruction word to the pipeline.
REQ-011 cpu_rst  output  1  reset to the pipeline core.
REQ-012 load_done  output  1  one-cycle pulse when a load completes.
REQ-013 words_loaded  output  DEPTH_LOG2+1  words written by the current or last load.
REQ-014 checksum  output  32  modulo-2^32 sum of words written by the current or last load.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, RUN; the state after reset SHALL be IDLE.
REQ-016 A byte transfer SHALL occur only in a cycle where byte_valid and byte_ready are both 1.
REQ-017 byte_ready SHALL be 1 only in LOAD, registered-state based, never depending combinationally on byte_valid.
REQ-018 Bytes SHALL assemble little-endian: first accepted byte -> bits 7:0, fourth -> bits 31:24.
REQ-019 On the fourth byte the full word SHALL be written to word index words_loaded in the same clock edge; words_loaded increments and checksum adds the word at that edge.
REQ-020 IDLE + load_start with load_len>0: go to LOAD, clear words_loaded, checksum, byte counter.
REQ-021 IDLE + load_start with load_len==0: go directly to RUN, clear counters, pulse load_done next cycle.
REQ-022 load_len greater than 2^DEPTH_LOG2 SHALL be clamped to 2^DEPTH_LOG2.
REQ-023 LOAD: after the edge writing word number load_len (effective), go to RUN and assert load_done for exactly the following cycle.
REQ-024 load_start during LOAD SHALL be ignored.
REQ-025 RUN + load_start: behave as IDLE + load_start (reload); memory contents not cleared, only overwritten.
REQ-026 cpu_rst SHALL be 1 whenever rst is 1 or state is not RUN; 0 in RUN.
REQ-027 IM_out SHALL be combinational: mem[IM_addr[DEPTH_LOG2+1:2]] in RUN; 32'h0 in IDLE and LOAD; IM_addr[1:0] and upper bits ignored.
REQ-028 byte_valid outside LOAD SHALL have no effect.
REQ-029 Partial words (fewer than 4 bytes) SHALL not be written.
REQ-030 Memory array SHALL be single write port, one combinational read port, no reset of contents.

Reset
REQ-031 rst SHALL force: state IDLE, byte counter 0, words_loaded 0, checksum 0, load_done 0, byte_ready 0, cpu_rst 1.
REQ-032 rst mid-LOAD SHALL abort the load; partial word discarded, previously written words retained in memory.
REQ-033 rst SHALL take priority over load_start and byte transfers in the same cycle.

Verification
REQ-034 Reset then load_start, load_len=2, bytes 01 02 03 04 05 06 07 08 with byte_valid held 1 -> words 32'h04030201, 32'h08070605 at index 0,1; load_done one cycle after eighth byte; checksum 32'h0C0A0806; words_loaded 2; cpu_rst falls same cycle as load_done.
REQ-035 RUN, IM_addr=32'h4 then 32'h7 -> IM_out 32'h08070605 both times; IM_addr=0 -> 32'h04030201.
REQ-036 Bytes with byte_valid toggling every other cycle, load_len=1 -> word assembled correctly, only valid cycles counted, IM_out 0 and cpu_rst 1 until done.
REQ-037 load_len=0 -> RUN next cycle, load_done pulse, byte_ready never 1, words_loaded 0, checksum 0.
REQ-038 rst asserted after 6 of 8 bytes -> IDLE, cpu_rst 1, words_loaded 0; new load of 1 word 32'hDEADBEEF then word 1 still 32'h0 only if never written, word 0 = 32'hDEADBEEF.
REQ-039 RUN reload with load_len=1, byte 0xFF x4 -> cpu_rst reasserted during LOAD, word 0 = 32'hFFFFFFFF, word 1 unchanged, checksum 32'hFFFFFFFF.
